// File: rtl/pipe_skid_stage_pkg.sv
// Shared rv32i pipeline constants and types for the skid-buffered pipeline stage.
package pipe_skid_stage_pkg;

    localparam int HOLD_FLAG_W = 3;
    localparam int DW_DEFAULT  = 32;

    typedef logic [HOLD_FLAG_W-1:0] hold_flag_t;

    localparam hold_flag_t HOLD_NONE = 3'd0;
    localparam hold_flag_t HOLD_PC   = 3'd1;
    localparam hold_flag_t HOLD_IF   = 3'd2;
    localparam hold_flag_t HOLD_ID   = 3'd3;

    localparam logic [31:0] INST_NOP  = 32'h0000_0013;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    function automatic logic hold_active(input hold_flag_t flag, input hold_flag_t lvl);
        return (flag >= lvl);
    endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready payload bus through one skid stage; slave is the stage's own view.
interface pipe_skid_stage_if
    import pipe_skid_stage_pkg::*;
#(
    parameter int DW = DW_DEFAULT
);
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;

    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o
    );

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o
    );
endinterface

// File: rtl/skid_entry_reg.sv
// One payload slot: loads on enable, clears to the bubble value on clear or reset.
module skid_entry_reg
    import pipe_skid_stage_pkg::*;
#(
    parameter int            DW      = DW_DEFAULT,
    parameter logic [DW-1:0] DEF_VAL = DW'(ZERO_WORD)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o
);

    logic [DW-1:0] data_d;
    logic [DW-1:0] data_q;

    always_comb begin
        if (clr_i) begin
            data_d = DEF_VAL;
        end else if (load_i) begin
            data_d = d_i;
        end else begin
            data_d = data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= DEF_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid pipeline stage with hold freeze, flush and a saturating stall counter.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int            DW       = DW_DEFAULT,
    parameter logic [DW-1:0] DEF_VAL  = DW'(ZERO_WORD),
    parameter hold_flag_t    HOLD_LVL = HOLD_ID
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  hold_flag_t          hold_flag_i,
    pipe_skid_stage_if.slave    bus,
    output logic [1:0]          occ_o,
    output logic [15:0]         stall_cnt_o
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]    state_d, state_q;
    logic [15:0]   stall_cnt_d, stall_cnt_q;
    logic          hold_en, accept, fire;
    logic          main_ld, main_clr, skid_ld, skid_clr;
    logic [DW-1:0] main_src, main_val, skid_val;

    assign hold_en         = hold_active(hold_flag_i, HOLD_LVL);
    assign bus.in_ready_o  = (state_q != ST_FULL) & ~hold_en & ~flush_i;
    assign bus.out_valid_o = (state_q != ST_EMPTY) & ~hold_en & ~flush_i;
    assign bus.out_data_o  = main_val;
    assign accept          = bus.in_valid_i & bus.in_ready_o;
    assign fire            = bus.out_valid_o & bus.out_ready_i;

    // Draining FULL promotes the skid entry; otherwise main loads straight from the input.
    always_comb begin
        if (state_q == ST_FULL) begin
            main_src = skid_val;
        end else begin
            main_src = bus.in_data_i;
        end
    end

    always_comb begin
        state_d  = state_q;
        main_ld  = 1'b0;
        main_clr = 1'b0;
        skid_ld  = 1'b0;
        skid_clr = 1'b0;
        if (flush_i) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_BUSY;
                        main_ld = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (accept && fire) begin
                        main_ld = 1'b1;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        skid_ld = 1'b1;
                    end else if (fire) begin
                        state_d  = ST_EMPTY;
                        main_clr = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
                ST_FULL: begin
                    if (fire) begin
                        state_d  = ST_BUSY;
                        main_ld  = 1'b1;
                        skid_clr = 1'b1;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d  = ST_EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    // Hold and flush both force out_valid low, so neither can count as a stall.
    always_comb begin
        if (bus.out_valid_o && !bus.out_ready_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    always_comb begin
        case (state_q)
            ST_EMPTY: occ_o = 2'd0;
            ST_BUSY:  occ_o = 2'd1;
            ST_FULL:  occ_o = 2'd2;
            default:  occ_o = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

    skid_entry_reg #(.DW(DW), .DEF_VAL(DEF_VAL)) u_main (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (main_clr),
        .load_i (main_ld),
        .d_i    (main_src),
        .q_o    (main_val)
    );

    skid_entry_reg #(.DW(DW), .DEF_VAL(DEF_VAL)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (skid_clr),
        .load_i (skid_ld),
        .d_i    (bus.in_data_i),
        .q_o    (skid_val)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Random and directed stimulus against a queue-based model of the skid stage.
module tb_pipe_skid_stage;
    import pipe_skid_stage_pkg::*;

    localparam logic [31:0] DEF = INST_NOP;

    logic        clk;
    logic        rst;
    logic        flush;
    hold_flag_t  hold_flag;
    logic [1:0]  occ;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit checking = 1'b0;

    logic [31:0] mq[$];
    int          e_stall = 0;

    pipe_skid_stage_if #(.DW(32)) bus ();

    pipe_skid_stage #(.DW(32), .DEF_VAL(DEF), .HOLD_LVL(HOLD_ID)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .hold_flag_i (hold_flag),
        .bus         (bus),
        .occ_o       (occ),
        .stall_cnt_o (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic f, input hold_flag_t h,
                         input logic iv, input logic [31:0] id, input logic ordy);
        logic        held, e_rdy, e_vld;
        logic [31:0] e_data;
        rst = r; flush = f; hold_flag = h;
        bus.in_valid_i = iv; bus.in_data_i = id; bus.out_ready_i = ordy;
        #2;
        held   = (h >= HOLD_ID);
        e_rdy  = (mq.size() < 2) && !held && !f;
        e_vld  = (mq.size() > 0) && !held && !f;
        e_data = (mq.size() > 0) ? mq[0] : DEF;
        if (checking) begin
            chk("in_ready",  {31'd0, bus.in_ready_o},  {31'd0, e_rdy});
            chk("out_valid", {31'd0, bus.out_valid_o}, {31'd0, e_vld});
            chk("out_data",  bus.out_data_o, e_data);
            chk("occ",       {30'd0, occ}, mq.size());
            chk("stall_cnt", {16'd0, stall_cnt}, e_stall);
        end
        @(posedge clk);
        if (r) begin
            mq.delete();
            e_stall = 0;
        end else begin
            if (e_vld && !ordy && e_stall < 65535) e_stall++;
            if (f) begin
                mq.delete();
            end else begin
                if (e_vld && ordy) void'(mq.pop_front());
                if (e_rdy && iv) mq.push_back(id);
            end
        end
        #1;
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, HOLD_NONE, 1'b0, 32'h0, ordy);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; hold_flag = HOLD_NONE;
        bus.in_valid_i = 1'b0; bus.in_data_i = 32'h0; bus.out_ready_i = 1'b0;
        #1;
        cycle(1'b1, 1'b0, HOLD_NONE, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, HOLD_NONE, 1'b0, 32'h0, 1'b0);
        checking = 1'b1;
        cycle(1'b1, 1'b0, HOLD_NONE, 1'b0, 32'h0, 1'b0);
        chk("reset_data", bus.out_data_o, DEF);

        // streaming
        cycle(1'b0, 1'b0, HOLD_NONE, 1'b1, 32'h11, 1'b1);
        cycle(1'b0, 1'b0, HOLD_NONE, 1'b1, 32'h22, 1'b1);
        cycle(1'b0, 1'b0, HOLD_NONE, 1'b1, 32'h33, 1'b1);
        idle(1'b1, 3);

        // back-pressure, third payload refused while FULL
        cycle(1'b0, 1'b0, HOLD_NONE, 1'b1, 32'hA1, 1'b0);
        cycle(1'b0, 1'b0, HOLD_NONE, 1'b1, 32'hA2, 1'b0);
        cycle(1'b0, 1'b0, HOLD_NONE, 1'b1, 32'hA3, 1'b0);
        idle(1'b0, 3);
        idle(1'b1, 3);

        // hold while FULL
        cycle(1'b0, 1'b0, HOLD_NONE, 1'b1, 32'hA1, 1'b0);
        cycle(1'b0, 1'b0, HOLD_NONE, 1'b1, 32'hA2, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, HOLD_ID, 1'b1, 32'h55, 1'b1);
        idle(1'b1, 3);

        // flush + hold + accept together
        cycle(1'b0, 1'b0, HOLD_NONE, 1'b1, 32'hB1, 1'b0);
        cycle(1'b0, 1'b0, HOLD_NONE, 1'b1, 32'hB2, 1'b0);
        cycle(1'b0, 1'b1, HOLD_ID, 1'b1, 32'hFF, 1'b1);
        chk("flush_occ", {30'd0, occ}, 32'd0);
        chk("flush_data", bus.out_data_o, DEF);
        idle(1'b1, 2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            hold_flag_t h;
            if ($urandom_range(0, 7) == 0) h = 3'($urandom_range(3, 7));
            else                           h = 3'($urandom_range(0, 2));
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0), h,
                  1'($urandom), $urandom, 1'($urandom));
        end

        // saturation
        cycle(1'b0, 1'b1, HOLD_NONE, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, HOLD_NONE, 1'b1, 32'hC1, 1'b0);
        idle(1'b0, 70000);
        chk("stall_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
        cycle(1'b1, 1'b0, HOLD_NONE, 1'b0, 32'h0, 1'b0);
        chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
        chk("rst_data", bus.out_data_o, DEF);
        idle(1'b1, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
